cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

- Instruction-cycle controller for the 8-bit accumulator CPU.
- Sits directly downstream of the clock generator: it waits for the first `fetch` pulse after reset, then steps an 8-state instruction cycle (S0–S7).
- In each state it issues the per-cycle strobes that drive the PC, instruction register, accumulator, memory and data bus.
- A HLT instruction parks it until reset.

## Interface
Parameters:
- `OP_W`, 3: opcode width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetch`  in  1  fetch phase from clock generator; first sample high enables sequencing.
- `opcode`  in  OP_W  instruction-register opcode field; valid from S2.
- `zero`  in  1  accumulator==0 flag.
- `inc_pc`  out  1  increment program counter.
- `load_pc`  out  1  load PC from IR address field.
- `load_ir`  out  1  load instruction byte from data bus.
- `load_acc`  out  1  load accumulator from ALU result.
- `rd`  out  1  memory read strobe.
- `wr`  out  1  memory write strobe.
- `datactl_ena`  out  1  drive ALU output onto data bus.
- `halt`  out  1  sticky halt indicator.

## Operation
Opcodes:
- HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- ALU class = ADD, AND, XOR, LDA.

States: IDLE, S0–S7, HALTED.

IDLE:
- `ena` flag clear; every output is 0.
- At an edge where `fetch`=1 is sampled, `ena` is set.
- At the next edge the state goes to S0.
- `ena` stays set until reset. `fetch` is ignored after that.

States and their asserted outputs (any output not listed is 0):
- S0: `rd`, `load_ir`, `inc_pc` (high instruction byte).
- S1: `rd`, `load_ir`, `inc_pc` (low byte).
- S2: decode only; no outputs. At the S2→S3 edge, `opcode` is latched into `op_q`. S3–S7 use `op_q` only.
- S3: no outputs, with one exception. If `op_q`=HLT, the next state is HALTED; otherwise it is S4.
- S4:
  - ALU class: `rd`.
  - STO: `datactl_ena`.
  - JMP: `load_pc`.
  - SKZ: nothing.
- S5:
  - ALU class: `rd`, `load_acc`.
  - STO: `datactl_ena`, `wr`.
  - JMP: `load_pc`.
  - SKZ with `zero` sampled 1: `inc_pc`. `zero` is sampled at the S4→S5 edge and held in `z_q`.
- S6:
  - STO: `datactl_ena`.
  - SKZ with `z_q`=1: `inc_pc`. Two increments in total skip one 2-byte instruction.
- S7: no outputs; the next state is S0 unconditionally.
- HALTED: `halt`=1, every other output 0; the state is held until reset.

## Timing
- All outputs are registered. At the edge that enters state Sk, the outputs take Sk's values; they are valid for that whole cycle. There are no combinational paths from inputs to outputs.
- Reset: asynchronous assert, clears immediately:
  - state = IDLE;
  - `ena`, `op_q`, `z_q` = 0;
  - all outputs = 0, including `halt`.
- Reset release: the first active edge after deassertion evaluates normally.
- Startup latency:
  - `fetch` sampled high at edge E → `ena` set at E.
  - S0 entered (S0 outputs high) at E+1.
- Instruction length: 8 cycles (S0..S7), back-to-back with no gaps. HLT is decided in S3, so HALTED is entered on the 5th edge of the instruction.
- `opcode` changes after S2 have no effect on the current instruction. `zero` changes after the S4→S5 edge have no effect.
- `wr` and `datactl_ena`: `wr` is never high unless `datactl_ena` is also high in the same cycle; `datactl_ena` brackets `wr` by one cycle on each side (S4, S6).
- Reset mid-instruction (any state, including HALTED): immediate return to IDLE; a fresh `fetch` is required to restart.
- Illegal or unreachable state encodings recover to IDLE on the next edge, with outputs 0.

## Structure
Shared package `cpu_pkg` holds:
- opcode localparams HLT..JMP;
- state encoding constants;
- `OP_W`.

Sub-module `op_class`:
- combinational;
- maps `op_q` to one-hot class flags `is_alu`, `is_sto`, `is_jmp`, `is_skz`, `is_hlt`.

Everything else (state register, `ena` flag, output registers) lives in `cpu_sequencer`.

## Test plan
- Startup:
  - stimulus: hold `reset`=0 for 3 cycles, release, pulse `fetch` high at edge E;
  - required: all outputs 0 before E+1; at E+1, `rd`=`load_ir`=`inc_pc`=1; the S0/S1 pattern repeats every 8 cycles.
- ADD then STO:
  - ADD: `rd` high in S4–S5, `load_acc` high only in S5;
  - STO: `datactl_ena` high in S4–S6, `wr` high only in S5, `rd`=0 in S4–S6.
- SKZ:
  - with `zero`=1 at the S4→S5 edge: `inc_pc` high in S5 and S6;
  - with `zero`=0: no `inc_pc` in S3–S7;
  - toggling `zero` after the sample changes nothing.
- JMP:
  - `load_pc` high in S4 and S5 only;
  - changing `opcode` to HLT during S3 still completes the JMP and does not halt.
- HLT:
  - `halt`=1 from the 5th edge of the instruction onward, every other output 0;
  - 50 further `fetch` pulses produce no change;
  - asserting `reset` clears `halt` asynchronously (checked before the next clock edge).
- Reset mid-op: assert `reset` during S5 of an LDA; `load_acc` and `rd` drop immediately, and the state is IDLE after release until `fetch`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode, state and control-strobe definitions
// for the 8-bit accumulator CPU.
package cpu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] HLT = 3'b000;
    localparam logic [OP_W-1:0] SKZ = 3'b001;
    localparam logic [OP_W-1:0] ADD = 3'b010;
    localparam logic [OP_W-1:0] AND = 3'b011;
    localparam logic [OP_W-1:0] XOR = 3'b100;
    localparam logic [OP_W-1:0] LDA = 3'b101;
    localparam logic [OP_W-1:0] STO = 3'b110;
    localparam logic [OP_W-1:0] JMP = 3'b111;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        S0     = 4'd1,
        S1     = 4'd2,
        S2     = 4'd3,
        S3     = 4'd4,
        S4     = 4'd5,
        S5     = 4'd6,
        S6     = 4'd7,
        S7     = 4'd8,
        HALTED = 4'd9
    } state_t;

    typedef struct packed {
        logic inc_pc;
        logic load_pc;
        logic load_ir;
        logic load_acc;
        logic rd;
        logic wr;
        logic datactl_ena;
        logic halt;
    } ctl_t;

endpackage

// File: rtl/op_class.sv
// Opcode classifier: maps the latched opcode to one-hot
// instruction-class flags.
module op_class #(
    parameter int OP_W = cpu_pkg::OP_W
) (
    input  logic [OP_W-1:0] op,
    output logic            is_alu,
    output logic            is_sto,
    output logic            is_jmp,
    output logic            is_skz,
    output logic            is_hlt
);
    import cpu_pkg::*;

    always_comb begin
        is_alu = 1'b0;
        is_sto = 1'b0;
        is_jmp = 1'b0;
        is_skz = 1'b0;
        is_hlt = 1'b0;
        case (op)
            HLT:               is_hlt = 1'b1;
            SKZ:               is_skz = 1'b1;
            ADD, AND, XOR, LDA: is_alu = 1'b1;
            STO:               is_sto = 1'b1;
            JMP:               is_jmp = 1'b1;
            default:           is_hlt = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller: steps S0..S7 per instruction
// and issues registered PC/IR/ACC/memory/bus strobes.
module cpu_sequencer #(
    parameter int OP_W = cpu_pkg::OP_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            inc_pc,
    output logic            load_pc,
    output logic            load_ir,
    output logic            load_acc,
    output logic            rd,
    output logic            wr,
    output logic            datactl_ena,
    output logic            halt
);
    import cpu_pkg::*;

    state_t          state, state_nx;
    logic            ena;
    logic [OP_W-1:0] op_q;
    logic            z_q;
    ctl_t            ctl, ctl_nx;
    logic            is_alu, is_sto, is_jmp, is_skz, is_hlt;

    op_class #(.OP_W(OP_W)) u_op_class (
        .op     (op_q),
        .is_alu (is_alu),
        .is_sto (is_sto),
        .is_jmp (is_jmp),
        .is_skz (is_skz),
        .is_hlt (is_hlt)
    );

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = ena ? S0 : IDLE;
            S0:      state_nx = S1;
            S1:      state_nx = S2;
            S2:      state_nx = S3;
            S3:      state_nx = is_hlt ? HALTED : S4;
            S4:      state_nx = S5;
            S5:      state_nx = S6;
            S6:      state_nx = S7;
            S7:      state_nx = S0;
            HALTED:  state_nx = HALTED;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are decoded from the state being entered so they
    // are registered; S5's skip uses the zero flag being sampled.
    always_comb begin
        ctl_nx = '0;
        case (state_nx)
            S0, S1: begin
                ctl_nx.rd      = 1'b1;
                ctl_nx.load_ir = 1'b1;
                ctl_nx.inc_pc  = 1'b1;
            end
            S4: begin
                ctl_nx.rd          = is_alu;
                ctl_nx.datactl_ena = is_sto;
                ctl_nx.load_pc     = is_jmp;
            end
            S5: begin
                ctl_nx.rd          = is_alu;
                ctl_nx.load_acc    = is_alu;
                ctl_nx.datactl_ena = is_sto;
                ctl_nx.wr          = is_sto;
                ctl_nx.load_pc     = is_jmp;
                ctl_nx.inc_pc      = is_skz & zero;
            end
            S6: begin
                ctl_nx.datactl_ena = is_sto;
                ctl_nx.inc_pc      = is_skz & z_q;
            end
            HALTED:  ctl_nx.halt = 1'b1;
            default: ctl_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ena   <= 1'b0;
            op_q  <= '0;
            z_q   <= 1'b0;
            ctl   <= '0;
        end else begin
            state <= state_nx;
            ctl   <= ctl_nx;
            if (state == IDLE && fetch)
                ena <= 1'b1;
            if (state == S2)
                op_q <= opcode;
            if (state == S4)
                z_q <= zero;
        end
    end

    assign inc_pc      = ctl.inc_pc;
    assign load_pc     = ctl.load_pc;
    assign load_ir     = ctl.load_ir;
    assign load_acc    = ctl.load_acc;
    assign rd          = ctl.rd;
    assign wr          = ctl.wr;
    assign datactl_ena = ctl.datactl_ena;
    assign halt        = ctl.halt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues the
// expected strobe vector per cycle, a monitor compares it.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fetch = 1'b0;
    logic       zero = 1'b0;
    logic [2:0] opcode = 3'b000;

    logic inc_pc, load_pc, load_ir, load_acc;
    logic rd, wr, datactl_ena, halt;

    localparam logic [7:0] INC  = 8'h01;
    localparam logic [7:0] LPC  = 8'h02;
    localparam logic [7:0] LIR  = 8'h04;
    localparam logic [7:0] LACC = 8'h08;
    localparam logic [7:0] RD   = 8'h10;
    localparam logic [7:0] WR   = 8'h20;
    localparam logic [7:0] DE   = 8'h40;
    localparam logic [7:0] HLTB = 8'h80;
    localparam logic [7:0] NONE = 8'h00;

    localparam logic [2:0] O_HLT = 3'b000;
    localparam logic [2:0] O_SKZ = 3'b001;
    localparam logic [2:0] O_ADD = 3'b010;
    localparam logic [2:0] O_AND = 3'b011;
    localparam logic [2:0] O_XOR = 3'b100;
    localparam logic [2:0] O_LDA = 3'b101;
    localparam logic [2:0] O_STO = 3'b110;
    localparam logic [2:0] O_JMP = 3'b111;

    cpu_sequencer #(.OP_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch       (fetch),
        .opcode      (opcode),
        .zero        (zero),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_ir     (load_ir),
        .load_acc    (load_acc),
        .rd          (rd),
        .wr          (wr),
        .datactl_ena (datactl_ena),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    wire [7:0] outs = {halt, datactl_ena, wr, rd,
                       load_acc, load_ir, load_pc, inc_pc};

    logic [7:0] expq[$];
    string      nameq[$];
    int         errors = 0;
    int         checks = 0;

    task automatic check(input logic [7:0] act, input logic [7:0] exp,
                         input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() != 0) begin
            logic [7:0] e;
            string      n;
            e = expq.pop_front();
            n = nameq.pop_front();
            check(outs, e, n);
        end
    end

    task automatic cyc(input logic [7:0] e, input string nm);
        @(posedge clk);
        #1;
        expq.push_back(e);
        nameq.push_back(nm);
    endtask

    task automatic instr(input logic [2:0] op, input bit z,
                         input bit mess, input string nm);
        logic [7:0] e4, e5, e6;
        case (op)
            O_STO: begin e4 = DE; e5 = DE | WR; e6 = DE; end
            O_JMP: begin e4 = LPC; e5 = LPC; e6 = NONE; end
            O_SKZ: begin
                e4 = NONE;
                e5 = z ? INC : NONE;
                e6 = z ? INC : NONE;
            end
            default: begin e4 = RD; e5 = RD | LACC; e6 = NONE; end
        endcase
        opcode = op;
        cyc(RD | LIR | INC, {nm, ".S0"});
        cyc(RD | LIR | INC, {nm, ".S1"});
        cyc(NONE, {nm, ".S2"});
        cyc(NONE, {nm, ".S3"});
        if (mess)
            opcode = O_HLT;
        if (op == O_HLT) begin
            cyc(HLTB, {nm, ".halted"});
            return;
        end
        cyc(e4, {nm, ".S4"});
        zero = z;
        cyc(e5, {nm, ".S5"});
        zero = ~z;
        cyc(e6, {nm, ".S6"});
        cyc(NONE, {nm, ".S7"});
    endtask

    initial begin
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc(NONE, "in_reset");
        reset = 1'b1;
        cyc(NONE, "idle0");
        cyc(NONE, "idle1");
        fetch = 1'b1;
        cyc(NONE, "edge_E");
        fetch = 1'b0;

        instr(O_ADD, 1'b0, 1'b0, "add");
        instr(O_STO, 1'b0, 1'b0, "sto");
        instr(O_SKZ, 1'b1, 1'b0, "skz1");
        instr(O_SKZ, 1'b0, 1'b0, "skz0");
        instr(O_JMP, 1'b0, 1'b1, "jmp");
        instr(O_XOR, 1'b1, 1'b0, "xor");

        // abort an LDA in S5
        opcode = O_LDA;
        cyc(RD | LIR | INC, "lda.S0");
        cyc(RD | LIR | INC, "lda.S1");
        cyc(NONE, "lda.S2");
        cyc(NONE, "lda.S3");
        cyc(RD, "lda.S4");
        cyc(RD | LACC, "lda.S5");
        @(negedge clk);
        #1 reset = 1'b0;
        #1 check(outs, NONE, "lda_abort_async");
        cyc(NONE, "abort_rst0");
        cyc(NONE, "abort_rst1");
        reset = 1'b1;
        for (int i = 0; i < 4; i++)
            cyc(NONE, "idle_after_abort");
        fetch = 1'b1;
        cyc(NONE, "edge_E2");
        fetch = 1'b0;

        instr(O_AND, 1'b0, 1'b0, "and");
        instr(O_HLT, 1'b0, 1'b0, "hlt");
        for (int i = 0; i < 50; i++) begin
            fetch = 1'b1;
            cyc(HLTB, "parked_f1");
            fetch = 1'b0;
            cyc(HLTB, "parked_f0");
        end
        @(negedge clk);
        #1 reset = 1'b0;
        #1 check(outs, NONE, "halt_async_clear");
        cyc(NONE, "hlt_rst");
        reset = 1'b1;
        cyc(NONE, "post_hlt_idle0");
        cyc(NONE, "post_hlt_idle1");
        @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d pending, required 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
